fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter and fetch sequencer driving the instruction-address side of the 5-stage pipelined CPU. It supplies the fetch address, advances on the CPU's PC+4 result and PC_Write (load-use stall) signal, and detects end of program. After the last fetch it drains the pipeline with NOP fetches, then reports done with cycle, stall and fetch statistics. It sits at the top level between the testbench/system controller and the CPU's Input_Addr/Output_Addr/PC_Write ports.

## Interface
- RESET_PC, 32'd0, first instruction address loaded on start.
- END_PC, 32'd128, first address past the program; instruction memory holds zeros (sll $0,$0,0 = NOP) at and beyond it.
- DRAIN_CYCLES, 4, non-stalled cycles after the last fetch before done (ID, EX, MEM, WB).
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin execution.
- PC_Write  in  1  from CPU; 1 = fetch accepted, 0 = load-use stall.
- Next_Addr  in  32  from CPU Output_Addr (Input_Addr + 4).
- Input_Addr  out  32  fetch address to CPU.
- running  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- cycle_count  out  32  cycles spent in RUN + DRAIN.
- stall_count  out  32  cycles with PC_Write = 0 in RUN or DRAIN.
- fetch_count  out  32  accepted fetches in RUN.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- Reset values: Input_Addr = END_PC, running = 0, done = 0, all counters 0, drain counter 0.
- IDLE: Input_Addr = END_PC (NOP fetch). On start: PC ← RESET_PC, clear counters.
  - If RESET_PC < END_PC (unsigned): go to RUN.
  - Otherwise: go to DRAIN with drain counter = DRAIN_CYCLES.
- RUN: Input_Addr = PC. Each cycle cycle_count += 1.
  - PC_Write = 1: PC ← {Next_Addr[31:2], 2'b00}, fetch_count += 1.
    - If Next_Addr ≥ END_PC: go to DRAIN with drain counter = DRAIN_CYCLES.
  - PC_Write = 0: PC held, stall_count += 1, stay in RUN.
- DRAIN: Input_Addr = END_PC. Next_Addr is ignored. Each cycle cycle_count += 1.
  - PC_Write = 1: drain counter −= 1.
  - PC_Write = 0: counter held, stall_count += 1. A stall of the last instruction extends the drain.
  - When the counter reaches 0 on a decrement: go to DONE.
- DONE: Input_Addr = END_PC, done = 1, counters frozen.
  - start restarts exactly as from IDLE, including the counter clear.
- start is ignored in RUN and DRAIN.
- Counters saturate at 32'hFFFFFFFF and do not wrap.
- rst asserted in any state, including mid-RUN or mid-DRAIN, returns to IDLE with reset values on the next edge. rst takes priority over start.

## Timing
- All outputs are registered; Input_Addr changes only on rising edges.
- start sampled at edge k → Input_Addr = RESET_PC and running = 1 from cycle k+1.
- Next_Addr is combinational from Input_Addr within the same cycle. The fetch-accept decision uses the PC_Write value present in that cycle.
- Last accepted fetch in cycle t with no stalls: DRAIN covers cycles t+1 through t+DRAIN_CYCLES, and done = 1 from cycle t+DRAIN_CYCLES+1. The last RF write completes at the edge ending cycle t+DRAIN_CYCLES.
- Each stall cycle in DRAIN delays done by exactly one cycle.
- running and done are never both high.

## Test plan
- Straight-line program, RESET_PC = 0, END_PC = 16, no stalls → fetches at 0, 4, 8, 12; DRAIN 4 cycles; done in cycle 9 after start; fetch_count = 4, stall_count = 0, cycle_count = 8.
- Load-use stall, PC_Write forced 0 for one cycle while Input_Addr = 8 → Input_Addr stays 8 for two cycles; fetch_count = 4, stall_count = 1, cycle_count = 9.
- Stall in DRAIN, PC_Write = 0 on the first DRAIN cycle → done one cycle later than the no-stall case; stall_count = 1, fetch_count = 4.
- rst pulsed mid-RUN at Input_Addr = 8 → next cycle Input_Addr = END_PC, running = 0, counters 0; start then restarts from RESET_PC.
- start asserted during RUN has no effect; start in DONE clears counters and reruns with identical final counts.
- RESET_PC = END_PC = 64 → start goes directly to DRAIN; done after 4 cycles; fetch_count = 0, cycle_count = 4.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-address link between the fetch sequencer and the CPU front end.
// The sequencer presents the fetch address; the CPU returns PC+4 and its stall flag.
interface fetch_sequencer_if;
  logic [31:0] Input_Addr;
  logic [31:0] Next_Addr;
  logic        PC_Write;

  modport master (
    output Input_Addr,
    input  Next_Addr,
    input  PC_Write
  );

  modport slave (
    input  Input_Addr,
    output Next_Addr,
    output PC_Write
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer: runs the program, drains the pipeline with NOP
// fetches after the last instruction, then reports done with cycle/stall/fetch statistics.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter logic [31:0] END_PC       = 32'd128,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  fetch_sequencer_if.master        bus,
  output logic                     running,
  output logic                     done,
  output logic [31:0]              cycle_count,
  output logic [31:0]              stall_count,
  output logic [31:0]              fetch_count
);

  localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES);
  localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // With no drain cycles configured, the last fetch goes straight to DONE.
  localparam state_e DrainEntry = (DRAIN_CYCLES == 0) ? StDone : StDrain;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       stall_q, stall_d;
  logic [31:0]       fetch_q, fetch_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  // Fetch addresses are word aligned; the low bits of PC+4 are dropped.
  logic [1:0] unused_next_addr_lsbs;
  assign unused_next_addr_lsbs = bus.Next_Addr[1:0];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    cycle_d = cycle_q;
    stall_d = stall_q;
    fetch_d = fetch_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc_d    = RESET_PC;
          cycle_d = '0;
          stall_d = '0;
          fetch_d = '0;
          if (RESET_PC < END_PC) begin
            state_d = StRun;
          end else begin
            state_d = DrainEntry;
            drain_d = DrainInit;
          end
        end
      end

      StRun: begin
        cycle_d = sat_inc(cycle_q);
        if (bus.PC_Write) begin
          pc_d    = {bus.Next_Addr[31:2], 2'b00};
          fetch_d = sat_inc(fetch_q);
          if (bus.Next_Addr >= END_PC) begin
            state_d = DrainEntry;
            drain_d = DrainInit;
          end
        end else begin
          stall_d = sat_inc(stall_q);
        end
      end

      StDrain: begin
        cycle_d = sat_inc(cycle_q);
        if (bus.PC_Write) begin
          drain_d = drain_q - DrainOne;
          if (drain_q == DrainOne) begin
            state_d = StDone;
          end
        end else begin
          // A stalled instruction in the pipe holds the drain count.
          stall_d = sat_inc(stall_q);
        end
      end

      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they change only on clock edges.
    addr_d    = (state_d == StRun) ? pc_d : END_PC;
    running_d = (state_d == StRun) || (state_d == StDrain);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      addr_q    <= END_PC;
      drain_q   <= '0;
      cycle_q   <= '0;
      stall_q   <= '0;
      fetch_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
      fetch_q   <= fetch_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.Input_Addr = addr_q;
  assign running        = running_q;
  assign done           = done_q;
  assign cycle_count    = cycle_q;
  assign stall_count    = stall_q;
  assign fetch_count    = fetch_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 4-instruction program (END_PC = 16) and an empty
// program (RESET_PC = END_PC = 64), with a PC+4 CPU stand-in driving Next_Addr.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic pw_a = 1'b1;
  logic pw_b = 1'b1;

  logic        running_a, done_a, running_b, done_b;
  logic [31:0] cyc_a, stall_a, fetch_a, cyc_b, stall_b, fetch_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] trace_q[$];

  always #5 clk = ~clk;

  fetch_sequencer_if bus_a ();
  fetch_sequencer_if bus_b ();

  assign bus_a.Next_Addr = bus_a.Input_Addr + 32'd4;
  assign bus_a.PC_Write  = pw_a;
  assign bus_b.Next_Addr = bus_b.Input_Addr + 32'd4;
  assign bus_b.PC_Write  = pw_b;

  fetch_sequencer #(
    .RESET_PC    (32'd0),
    .END_PC      (32'd16),
    .DRAIN_CYCLES(4)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .bus        (bus_a),
    .running    (running_a),
    .done       (done_a),
    .cycle_count(cyc_a),
    .stall_count(stall_a),
    .fetch_count(fetch_a)
  );

  fetch_sequencer #(
    .RESET_PC    (32'd64),
    .END_PC      (32'd64),
    .DRAIN_CYCLES(4)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .bus        (bus_b),
    .running    (running_b),
    .done       (done_b),
    .cycle_count(cyc_b),
    .stall_count(stall_b),
    .fetch_count(fetch_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then plays the CPU until done. Cycle 1 is the first cycle after start.
  task automatic run_a(input logic [31:0] stall_at, input int drain_stall, input bit start_mid,
                       output int done_cyc);
    bit stalled = 1'b0;
    int drain_idx = 0;
    done_cyc = 0;
    trace_q.delete();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      check_eq("run_done_excl", {31'd0, running_a & done_a}, 32'd0);
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
      pw_a = 1'b1;
      if (running_a && bus_a.Input_Addr != 32'd16) begin
        trace_q.push_back(bus_a.Input_Addr);
        if (bus_a.Input_Addr == stall_at && !stalled) begin
          pw_a = 1'b0;
          stalled = 1'b1;
        end
      end else if (running_a) begin
        drain_idx++;
        if (drain_idx == drain_stall) pw_a = 1'b0;
      end
      start_a = start_mid && (cyc == 2);
      step();
    end
    start_a = 1'b0;
    pw_a = 1'b1;
    if (done_cyc == 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_run(input string tag, input int done_cyc, input int exp_done,
                           input int exp_cyc, input int exp_stall, input bit stall_at_8);
    logic [31:0] exp_q[$];
    if (stall_at_8) exp_q = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12};
    else            exp_q = '{32'd0, 32'd4, 32'd8, 32'd12};
    check_eq({tag, "_done_cycle"}, done_cyc, exp_done);
    check_eq({tag, "_cycle_count"}, cyc_a, exp_cyc);
    check_eq({tag, "_stall_count"}, stall_a, exp_stall);
    check_eq({tag, "_fetch_count"}, fetch_a, 32'd4);
    check_eq({tag, "_trace_len"}, trace_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++) begin
      check_eq({tag, "_trace_addr"}, trace_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int dc;
    step();
    step();
    // Reset state, checked while rst is held and again after release.
    check_eq("rst_addr_a", bus_a.Input_Addr, 32'd16);
    check_eq("rst_running", {31'd0, running_a}, 32'd0);
    check_eq("rst_done", {31'd0, done_a}, 32'd0);
    check_eq("rst_counts", cyc_a | stall_a | fetch_a, 32'd0);
    check_eq("rst_addr_b", bus_b.Input_Addr, 32'd64);
    rst = 1'b0;
    step();
    check_eq("idle_addr", bus_a.Input_Addr, 32'd16);
    check_eq("idle_running", {31'd0, running_a}, 32'd0);

    // Straight-line program, no stalls.
    run_a(32'hFFFF_FFFF, 0, 1'b0, dc);
    check_run("plain", dc, 9, 8, 0, 1'b0);
    step();
    step();
    check_eq("done_freeze_cyc", cyc_a, 32'd8);
    check_eq("done_hold", {31'd0, done_a}, 32'd1);
    check_eq("done_addr", bus_a.Input_Addr, 32'd16);

    // Restart from DONE clears counters and gives identical results.
    run_a(32'hFFFF_FFFF, 0, 1'b0, dc);
    check_run("rerun", dc, 9, 8, 0, 1'b0);

    // Load-use stall at address 8.
    run_a(32'd8, 0, 1'b0, dc);
    check_run("ldstall", dc, 10, 9, 1, 1'b1);

    // Stall on the first drain cycle.
    run_a(32'hFFFF_FFFF, 1, 1'b0, dc);
    check_run("drstall", dc, 10, 9, 1, 1'b0);

    // start during RUN is ignored.
    run_a(32'hFFFF_FFFF, 0, 1'b1, dc);
    check_run("startrun", dc, 9, 8, 0, 1'b0);

    // Reset mid-RUN at Input_Addr = 8.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 10 && bus_a.Input_Addr != 32'd8; i++) step();
    check_eq("mid_reach8", bus_a.Input_Addr, 32'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_addr", bus_a.Input_Addr, 32'd16);
    check_eq("mid_rst_running", {31'd0, running_a}, 32'd0);
    check_eq("mid_rst_counts", cyc_a | stall_a | fetch_a, 32'd0);
    run_a(32'hFFFF_FFFF, 0, 1'b0, dc);
    check_run("after_rst", dc, 9, 8, 0, 1'b0);

    // Empty program: RESET_PC = END_PC goes straight to DRAIN.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check_eq("empty_running", {31'd0, running_b}, 32'd1);
    check_eq("empty_addr", bus_b.Input_Addr, 32'd64);
    dc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done_b) begin
        dc = cyc;
        break;
      end
      step();
    end
    check_eq("empty_done_cycle", dc, 32'd5);
    check_eq("empty_cycle_count", cyc_b, 32'd4);
    check_eq("empty_fetch_count", fetch_b, 32'd0);
    check_eq("empty_stall_count", stall_b, 32'd0);
    check_eq("empty_running_off", {31'd0, running_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
